// File: rtl/multicore_mem_arbiter.sv
// multicore_mem_arbiter: round-robin arbiter of NUM_CORES core memory ports onto one shared memory; optional ARB_PERF_CNT_EN adds per-core wait counters
module multicore_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES-1:0]            core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]     core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]     core_wdata,
  input  logic [NUM_CORES*DATA_W/8-1:0]   core_be,
  output logic [NUM_CORES-1:0]            core_done,
  output logic [DATA_W-1:0]               core_rdata,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_be,
  input  logic                            mem_ack,
  input  logic [DATA_W-1:0]               mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [NUM_CORES*32-1:0]         perf_wait
`endif
);
  localparam int IW = $clog2(NUM_CORES);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [IW-1:0] winner, last_grant, pick, idx;
  // round-robin pick: descending scan so the nearest requester after last_grant wins
  always_comb begin
    pick = last_grant;
    idx = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_CORES);
      if (core_req[idx]) pick = idx;
    end
  end
  // transaction FSM: latch the winner onto the memory port, wait for ack, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner     <= '0;
      last_grant <= IW'(NUM_CORES - 1);
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      core_done  <= '0;
      core_rdata <= '0;
    end else begin
      core_done <= '0;
      case (state)
        IDLE: if (|core_req) begin
          winner    <= pick;
          mem_we    <= core_we[pick];
          mem_addr  <= core_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_wdata <= core_wdata[int'(pick)*DATA_W +: DATA_W];
          mem_be    <= core_be[int'(pick)*BW +: BW];
          mem_req   <= 1'b1;
          state     <= BUSY;
        end
        BUSY: if (mem_ack) begin
          core_rdata        <= mem_rdata;
          mem_req           <= 1'b0;
          core_done[winner] <= 1'b1;
          last_grant        <= winner;
          state             <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_PERF_CNT_EN
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_perf
    logic served;
    assign served = (state == IDLE) ? (pick == IW'(i)) : (winner == IW'(i));
    // count cycles a core requests while another core owns (or is being granted) the memory
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_wait[i*32 +: 32] <= '0;
      else if (core_req[i] && !served && !(&perf_wait[i*32 +: 32])) perf_wait[i*32 +: 32] <= perf_wait[i*32 +: 32] + 32'd1;
    end
  end
`endif
endmodule
